div_wb_ctrl: RTL and testbench

- Sits between the issue stage, the iterative divider and the register-file write port.
- Tracks the one divide/remainder in flight and stalls issue on hazards against it.
- Merges the divider's writeback with the main execute writeback (execute has priority), holding a colliding divider result in a one-entry buffer.
- Discards results of divides squashed by a pipeline flush.

---
 rtl/div_wb_ctrl.sv | 155 +++++++++++++++
 tb/tb_div_wb_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_wb_ctrl.sv
// Divide writeback controller: tracks one in-flight divide, stalls issue on hazards,
// merges divider results behind execute writeback. Optional watchdog: DIV_WB_TIMEOUT_EN.
module div_wb_ctrl #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue_valid_i,
    input  logic        issue_is_div_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic [4:0]  issue_ra_idx_i,
    input  logic [4:0]  issue_rb_idx_i,
    output logic        issue_stall_o,
    input  logic        flush_i,
    input  logic        div_wb_valid_i,
    input  logic [31:0] div_wb_value_i,
    input  logic        exec_wb_valid_i,
    input  logic [4:0]  exec_wb_rd_i,
    input  logic [31:0] exec_wb_value_i,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_idx_o,
    output logic [31:0] rf_wr_value_o,
    output logic        div_timeout_o
);

    typedef enum logic [1:0] {IDLE, PENDING, KILLED, BUFFERED} state_e;

    state_e      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] buf_q, buf_d;
    logic        rd_match;
    logic        div_accept;
    logic        div_wr;
    logic [31:0] div_val;
    logic        timeout_hit;

    always_comb begin
        rd_match      = (rd_q != 5'd0) &&
                        ((rd_q == issue_ra_idx_i) || (rd_q == issue_rb_idx_i) ||
                         (rd_q == issue_rd_idx_i));
        // KILLED only blocks a new divide; its result never reaches the register file
        issue_stall_o = issue_valid_i &&
                        ((issue_is_div_i && (state_q != IDLE)) ||
                         (((state_q == PENDING) || (state_q == BUFFERED)) && rd_match));
        div_accept    = issue_valid_i && issue_is_div_i && !issue_stall_o;
    end

`ifdef DIV_WB_TIMEOUT_EN
    logic [5:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        timeout_hit = 1'b0;
        if (div_accept) begin
            cnt_d = 6'd0;
        end else if ((state_q == PENDING) || (state_q == KILLED)) begin
            cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
            if (cnt_d == 6'(TIMEOUT_CYCLES)) begin
                timeout_hit = 1'b1;
                timeout_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= 6'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign div_timeout_o = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign div_timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        buf_d   = buf_q;
        div_wr  = 1'b0;
        div_val = 32'd0;
        case (state_q)
            IDLE: begin
                if (div_accept) begin
                    rd_d    = issue_rd_idx_i;
                    state_d = flush_i ? KILLED : PENDING;
                end
            end
            PENDING: begin
                if (flush_i) begin
                    state_d = div_wb_valid_i ? IDLE : KILLED;
                end else if (div_wb_valid_i) begin
                    if (exec_wb_valid_i) begin
                        buf_d   = div_wb_value_i;
                        state_d = BUFFERED;
                    end else begin
                        div_wr  = 1'b1;
                        div_val = div_wb_value_i;
                        state_d = IDLE;
                    end
                end
            end
            KILLED: begin
                if (div_wb_valid_i) state_d = IDLE;
            end
            BUFFERED: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (!exec_wb_valid_i) begin
                    div_wr  = 1'b1;
                    div_val = buf_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rd_q    <= 5'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            buf_q   <= buf_d;
        end
    end

    // Execute owns the port when active; a divide write to x0 is swallowed entirely
    always_comb begin
        rf_wr_en_o    = 1'b0;
        rf_wr_idx_o   = 5'd0;
        rf_wr_value_o = 32'd0;
        if (exec_wb_valid_i) begin
            rf_wr_en_o    = 1'b1;
            rf_wr_idx_o   = exec_wb_rd_i;
            rf_wr_value_o = exec_wb_value_i;
        end else if (div_wr && (rd_q != 5'd0)) begin
            rf_wr_en_o    = 1'b1;
            rf_wr_idx_o   = rd_q;
            rf_wr_value_o = div_val;
        end
    end

endmodule

// File: tb/tb_div_wb_ctrl.sv
// Scoreboard bench for div_wb_ctrl: expected writes queued by stimulus, checked by a monitor.
module tb_div_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i, issue_is_div_i;
    logic [4:0]  issue_rd_idx_i, issue_ra_idx_i, issue_rb_idx_i;
    logic        issue_stall_o;
    logic        flush_i;
    logic        div_wb_valid_i;
    logic [31:0] div_wb_value_i;
    logic        exec_wb_valid_i;
    logic [4:0]  exec_wb_rd_i;
    logic [31:0] exec_wb_value_i;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_idx_o;
    logic [31:0] rf_wr_value_o;
    logic        div_timeout_o;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] val;
    } wr_t;

    wr_t sb[$];
    int  total  = 0;
    int  passed = 0;

    div_wb_ctrl #(.TIMEOUT_CYCLES(40)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_is_div_i(issue_is_div_i),
        .issue_rd_idx_i(issue_rd_idx_i), .issue_ra_idx_i(issue_ra_idx_i),
        .issue_rb_idx_i(issue_rb_idx_i), .issue_stall_o(issue_stall_o),
        .flush_i(flush_i),
        .div_wb_valid_i(div_wb_valid_i), .div_wb_value_i(div_wb_value_i),
        .exec_wb_valid_i(exec_wb_valid_i), .exec_wb_rd_i(exec_wb_rd_i),
        .exec_wb_value_i(exec_wb_value_i),
        .rf_wr_en_o(rf_wr_en_o), .rf_wr_idx_o(rf_wr_idx_o),
        .rf_wr_value_o(rf_wr_value_o), .div_timeout_o(div_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            if (rf_wr_en_o) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_wr: got x%0d=%0h, expected no write",
                             rf_wr_idx_o, rf_wr_value_o);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_idx", 64'(rf_wr_idx_o), 64'(e.idx));
                    chk("wr_val", 64'(rf_wr_value_o), 64'(e.val));
                end
            end else begin
                chk("idle_port_zero", {rf_wr_idx_o, rf_wr_value_o}, 64'd0);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic d, input logic [4:0] rd,
                         input logic [4:0] ra, input logic [4:0] rb);
        issue_valid_i  = v;
        issue_is_div_i = d;
        issue_rd_idx_i = rd;
        issue_ra_idx_i = ra;
        issue_rb_idx_i = rb;
    endtask

    task automatic clr_all();
        issue(0, 0, 0, 0, 0);
        flush_i         = 0;
        div_wb_valid_i  = 0;
        div_wb_value_i  = 0;
        exec_wb_valid_i = 0;
        exec_wb_rd_i    = 0;
        exec_wb_value_i = 0;
    endtask

    task automatic pulse(input logic [31:0] v);
        div_wb_valid_i = 1;
        div_wb_value_i = v;
    endtask

    // Look at the stall for a divide without letting it be accepted
    task automatic probe_div(input string nm, input logic exp);
        issue(1, 1, 5'd30, 5'd29, 5'd28);
        @(negedge clk);
        chk(nm, 64'(issue_stall_o), 64'(exp));
        issue(0, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        clr_all();
        rst_ni = 0;
        repeat (2) nxt();
        issue(1, 1, 5'd5, 5'd5, 5'd5);
        @(negedge clk);
        chk("rst_stall", 64'(issue_stall_o), 0);
        chk("rst_wr_en", 64'(rf_wr_en_o), 0);
        chk("rst_port", {rf_wr_idx_o, rf_wr_value_o}, 0);
        chk("rst_timeout", 64'(div_timeout_o), 0);
        clr_all();
        nxt();
        rst_ni = 1;
        nxt();

        // DIV x5 then dependent ADD, result 34 cycles later
        issue(1, 1, 5'd5, 5'd1, 5'd2);
        @(negedge clk);
        chk("t1_div_accept", 64'(issue_stall_o), 0);
        nxt();
        issue(1, 0, 5'd6, 5'd5, 5'd7);
        n = 0;
        for (int i = 0; i < 34; i++) begin
            if (i == 33) begin
                pulse(32'h7);
                sb.push_back('{5'd5, 32'h7});
            end
            @(negedge clk);
            if (issue_stall_o) n++;
            if (i == 33) chk("t1_wr_en", 64'(rf_wr_en_o), 1);
            nxt();
        end
        chk("t1_stall_cycles", 64'(n), 64'd34);
        div_wb_valid_i = 0;
        @(negedge clk);
        chk("t1_add_release", 64'(issue_stall_o), 0);
        nxt();
        clr_all();

        // collision with execute writeback
        issue(1, 1, 5'd9, 5'd0, 5'd0);
        nxt();
        clr_all();
        nxt();
        pulse(32'h1234);
        exec_wb_valid_i = 1; exec_wb_rd_i = 5'd3; exec_wb_value_i = 32'hAA;
        sb.push_back('{5'd3, 32'hAA});
        sb.push_back('{5'd9, 32'h1234});
        @(negedge clk);
        chk("t2_exec_idx", 64'(rf_wr_idx_o), 64'd3);
        nxt();
        clr_all();
        issue(1, 0, 5'd12, 5'd9, 5'd0);
        @(negedge clk);
        chk("t2_buf_wr_en", 64'(rf_wr_en_o), 1);
        chk("t2_buf_stall", 64'(issue_stall_o), 1);
        nxt();
        @(negedge clk);
        chk("t2_release", 64'(issue_stall_o), 0);
        nxt();
        clr_all();

        // back-to-back divides
        issue(1, 1, 5'd10, 5'd0, 5'd0);
        nxt();
        issue(1, 1, 5'd11, 5'd12, 5'd13);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (issue_stall_o) n++;
            nxt();
        end
        chk("t3_div_stall_cycles", 64'(n), 64'd5);
        pulse(32'h55);
        sb.push_back('{5'd10, 32'h55});
        @(negedge clk);
        chk("t3_stall_at_pulse", 64'(issue_stall_o), 1);
        nxt();
        div_wb_valid_i = 0;
        @(negedge clk);
        chk("t3_second_accept", 64'(issue_stall_o), 0);
        nxt();
        clr_all();
        nxt();
        pulse(32'h66);
        sb.push_back('{5'd11, 32'h66});
        @(negedge clk);
        chk("t3_second_wr", 64'(rf_wr_en_o), 1);
        nxt();
        clr_all();

        // flush while pending, late result dropped
        issue(1, 1, 5'd4, 5'd0, 5'd0);
        nxt();
        clr_all();
        flush_i = 1;
        nxt();
        flush_i = 0;
        issue(1, 0, 5'd14, 5'd4, 5'd4);
        @(negedge clk);
        chk("t4_killed_no_raw", 64'(issue_stall_o), 0);
        nxt();
        issue(1, 1, 5'd20, 5'd21, 5'd22);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (issue_stall_o) n++;
            nxt();
        end
        chk("t4_div_stall_cycles", 64'(n), 64'd3);
        pulse(32'hDEAD);
        @(negedge clk);
        chk("t4_stall_at_pulse", 64'(issue_stall_o), 1);
        chk("t4_no_write", 64'(rf_wr_en_o), 0);
        nxt();
        div_wb_valid_i = 0;
        @(negedge clk);
        chk("t4_div_accept", 64'(issue_stall_o), 0);
        nxt();
        clr_all();
        pulse(32'h77);
        sb.push_back('{5'd20, 32'h77});
        nxt();
        clr_all();

        // divide to x0
        issue(1, 1, 5'd0, 5'd0, 5'd0);
        nxt();
        issue(1, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("t5_x0_no_stall", 64'(issue_stall_o), 0);
        nxt();
        issue(1, 1, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        chk("t5_div_stall", 64'(issue_stall_o), 1);
        nxt();
        pulse(32'h99);
        @(negedge clk);
        chk("t5_x0_wr_en", 64'(rf_wr_en_o), 0);
        chk("t5_stall_at_pulse", 64'(issue_stall_o), 1);
        nxt();
        div_wb_valid_i = 0;
        @(negedge clk);
        chk("t5_div_accept", 64'(issue_stall_o), 0);
        nxt();
        clr_all();
        pulse(32'h11);
        sb.push_back('{5'd1, 32'h11});
        nxt();
        clr_all();

        // divide accepted together with flush is squashed
        issue(1, 1, 5'd8, 5'd0, 5'd0);
        flush_i = 1;
        @(negedge clk);
        chk("t6_accept", 64'(issue_stall_o), 0);
        nxt();
        clr_all();
        probe_div("t6_killed_div_stall", 1);
        nxt();
        pulse(32'hBEEF);
        @(negedge clk);
        chk("t6_no_write", 64'(rf_wr_en_o), 0);
        nxt();
        clr_all();
        probe_div("t6_idle_after", 0);
        nxt();

        // buffered result held by busy execute, then flushed
        issue(1, 1, 5'd7, 5'd0, 5'd0);
        nxt();
        clr_all();
        pulse(32'h500);
        exec_wb_valid_i = 1; exec_wb_rd_i = 5'd2; exec_wb_value_i = 32'h42;
        sb.push_back('{5'd2, 32'h42});
        nxt();
        div_wb_valid_i = 0;
        exec_wb_rd_i = 5'd3; exec_wb_value_i = 32'h43;
        sb.push_back('{5'd3, 32'h43});
        @(negedge clk);
        chk("t7_exec_hold_idx", 64'(rf_wr_idx_o), 64'd3);
        nxt();
        clr_all();
        flush_i = 1;
        @(negedge clk);
        chk("t7_flush_no_write", 64'(rf_wr_en_o), 0);
        nxt();
        clr_all();
        probe_div("t7_idle_after", 0);
        nxt();

        // stray result in IDLE
        pulse(32'h999);
        @(negedge clk);
        chk("t8_idle_ignored", 64'(rf_wr_en_o), 0);
        nxt();
        clr_all();

`ifdef DIV_WB_TIMEOUT_EN
        issue(1, 1, 5'd13, 5'd0, 5'd0);
        nxt();
        clr_all();
        repeat (39) nxt();
        @(negedge clk);
        chk("t9_timeout_before", 64'(div_timeout_o), 0);
        nxt();
        @(negedge clk);
        chk("t9_timeout_set", 64'(div_timeout_o), 1);
        probe_div("t9_idle_after_timeout", 0);
        nxt();
        pulse(32'h3);
        @(negedge clk);
        chk("t9_late_dropped", 64'(rf_wr_en_o), 0);
        nxt();
        clr_all();
`endif

        // reset mid-divide
        issue(1, 1, 5'd5, 5'd0, 5'd0);
        nxt();
        issue(1, 1, 5'd6, 5'd0, 5'd0);
        @(negedge clk);
        chk("t10_stall_before_rst", 64'(issue_stall_o), 1);
        rst_ni = 0;
        #1;
        chk("t10_rst_stall", 64'(issue_stall_o), 0);
        chk("t10_rst_wr_en", 64'(rf_wr_en_o), 0);
        chk("t10_rst_port", {rf_wr_idx_o, rf_wr_value_o}, 0);
        chk("t10_rst_timeout", 64'(div_timeout_o), 0);
        clr_all();
        nxt();
        rst_ni = 1;
        nxt();
        probe_div("t10_idle_after_rst", 0);
        nxt();

        chk("sb_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
